utm_step_controller: RTL and testbench

//  Sequences one Turing-machine step per iteration: read tape cell, present {state, symbol} to the

---
 rtl/utm_pkg.sv | 32 +++
 rtl/utm_head_ptr.sv | 46 ++++
 rtl/utm_step_controller.sv | 206 ++++++++++++++++++++
 tb/tb_utm_step_controller.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utm_pkg.sv
// Shared types and constants for the Turing-machine step controller.
package utm_pkg;

    localparam int SYM_W   = 3;
    localparam int STATE_W = 8;

    // Tape symbol that no transition table entry may consume.
    localparam logic [SYM_W-1:0] SYM_INVALID = 3'b011;

    // Error codes reported on err.
    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_BAD_STATE = 2'b01;
    localparam logic [1:0] ERR_BAD_SYM   = 2'b10;
    localparam logic [1:0] ERR_TAPE_EDGE = 2'b11;

    // Step sequencer states.
    typedef enum logic [2:0] {
        FSM_IDLE   = 3'd0,
        FSM_READ   = 3'd1,
        FSM_DECODE = 3'd2,
        FSM_WRITE  = 3'd3,
        FSM_MOVE   = 3'd4,
        FSM_PAUSE  = 3'd5,
        FSM_HALT   = 3'd6
    } fsm_state_e;

    // True when exactly one bit of x is set.
    function automatic logic is_one_hot(input logic [STATE_W-1:0] x);
        return (x != '0) && ((x & (x - STATE_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/utm_head_ptr.sv
// Bounded up/down head pointer: never wraps, reports when it sits on either edge.
module utm_head_ptr #(
    parameter int                HEAD_W   = 8,
    parameter logic [HEAD_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              move,
    input  logic              dir,
    output logic [HEAD_W-1:0] head,
    output logic              at_min,
    output logic              at_max
);

    logic [HEAD_W-1:0] head_d;
    logic [HEAD_W-1:0] head_q;

    assign at_min = (head_q == '0);
    assign at_max = &head_q;
    assign head   = head_q;

    // Next head position: load wins, a move past either edge leaves the head in place.
    always_comb begin
        head_d = head_q;
        if (load) begin
            head_d = INIT_VAL;
        end else if (move) begin
            if (dir && !at_max) begin
                head_d = head_q + HEAD_W'(1);
            end else if (!dir && !at_min) begin
                head_d = head_q - HEAD_W'(1);
            end
        end
    end

    // Head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= INIT_VAL;
        end else begin
            head_q <= head_d;
        end
    end

endmodule

// File: rtl/utm_step_controller.sv
// Runs one Turing-machine step per iteration: read cell, look up transition, write cell, move head.
// Tape port: req/we/addr/wdata are registered and held until ack is sampled high while req is high;
// req is low for at least one cycle after every ack, so each req assertion is one transaction.
module utm_step_controller
    import utm_pkg::*;
#(
    parameter int                 HEAD_W     = 8,
    parameter int                 STEP_W     = 16,
    parameter logic [STATE_W-1:0] INIT_STATE = 8'h01,
    parameter int                 HEAD_INIT  = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               single_step,
    input  logic               step_go,
    output logic               busy,
    output logic               halted,
    output logic [1:0]         err,
    output logic [STATE_W-1:0] state_q,
    output logic [HEAD_W-1:0]  head,
    output logic [STEP_W-1:0]  step_count,
    output logic               tape_req,
    output logic               tape_we,
    output logic [HEAD_W-1:0]  tape_addr,
    output logic [SYM_W-1:0]   tape_wdata,
    input  logic [SYM_W-1:0]   tape_rdata,
    input  logic               tape_ack,
    output logic [STATE_W-1:0] lut_state,
    output logic [SYM_W-1:0]   lut_sym,
    input  logic [STATE_W-1:0] lut_next_state,
    input  logic [SYM_W-1:0]   lut_wsym,
    input  logic               lut_dir,
    output fsm_state_e         fsm_dbg
);

    fsm_state_e         fsm_d,    fsm_q;
    logic [STATE_W-1:0] mstate_d, mstate_q;
    logic [STEP_W-1:0]  step_d,   step_q;
    logic [1:0]         err_d,    err_q;
    logic               req_d,    req_q;
    logic               we_d,     we_q;
    logic [SYM_W-1:0]   wdata_d,  wdata_q;
    logic [SYM_W-1:0]   sym_d,    sym_q;
    logic [STATE_W-1:0] ns_d,     ns_q;
    logic               dir_d,    dir_q;

    logic head_load;
    logic head_move;
    logic at_min;
    logic at_max;
    logic xfer_done;

    utm_head_ptr #(
        .HEAD_W   (HEAD_W),
        .INIT_VAL (HEAD_W'(HEAD_INIT))
    ) u_head (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (head_load),
        .move   (head_move),
        .dir    (dir_q),
        .head   (head),
        .at_min (at_min),
        .at_max (at_max)
    );

    // An ack only counts while a request is outstanding.
    assign xfer_done = req_q && tape_ack;

    // Step sequencing: next FSM state, machine registers and tape request fields.
    always_comb begin
        fsm_d     = fsm_q;
        mstate_d  = mstate_q;
        step_d    = step_q;
        err_d     = err_q;
        req_d     = req_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        sym_d     = sym_q;
        ns_d      = ns_q;
        dir_d     = dir_q;
        head_load = 1'b0;
        head_move = 1'b0;

        case (fsm_q)
            FSM_IDLE, FSM_HALT: begin
                if (start) begin
                    fsm_d     = FSM_READ;
                    mstate_d  = INIT_STATE;
                    step_d    = '0;
                    err_d     = ERR_NONE;
                    head_load = 1'b1;
                    req_d     = 1'b1;
                    we_d      = 1'b0;
                end
            end
            FSM_READ: begin
                if (xfer_done) begin
                    sym_d = tape_rdata;
                    req_d = 1'b0;
                    fsm_d = FSM_DECODE;
                end
            end
            FSM_DECODE: begin
                if (sym_q == SYM_INVALID) begin
                    err_d = ERR_BAD_SYM;
                    fsm_d = FSM_HALT;
                end else begin
                    ns_d    = lut_next_state;
                    dir_d   = lut_dir;
                    wdata_d = lut_wsym;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    fsm_d   = FSM_WRITE;
                end
            end
            FSM_WRITE: begin
                if (xfer_done) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    fsm_d = FSM_MOVE;
                end
            end
            FSM_MOVE: begin
                step_d = (&step_q) ? step_q : step_q + STEP_W'(1);
                if (ns_q == '0) begin
                    mstate_d = ns_q;
                    err_d    = ERR_NONE;
                    fsm_d    = FSM_HALT;
                end else if (!is_one_hot(ns_q)) begin
                    err_d = ERR_BAD_STATE;
                    fsm_d = FSM_HALT;
                end else begin
                    mstate_d = ns_q;
                    if ((!dir_q && at_min) || (dir_q && at_max)) begin
                        err_d = ERR_TAPE_EDGE;
                        fsm_d = FSM_HALT;
                    end else begin
                        head_move = 1'b1;
                        if (single_step) begin
                            fsm_d = FSM_PAUSE;
                        end else begin
                            fsm_d = FSM_READ;
                            req_d = 1'b1;
                            we_d  = 1'b0;
                        end
                    end
                end
            end
            FSM_PAUSE: begin
                if (step_go) begin
                    fsm_d = FSM_READ;
                    req_d = 1'b1;
                    we_d  = 1'b0;
                end
            end
            default: begin
                fsm_d = FSM_IDLE;
                req_d = 1'b0;
                we_d  = 1'b0;
            end
        endcase
    end

    // All controller state registers; reset drops the tape request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= FSM_IDLE;
            mstate_q <= INIT_STATE;
            step_q   <= '0;
            err_q    <= ERR_NONE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            sym_q    <= '0;
            ns_q     <= '0;
            dir_q    <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            mstate_q <= mstate_d;
            step_q   <= step_d;
            err_q    <= err_d;
            req_q    <= req_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            sym_q    <= sym_d;
            ns_q     <= ns_d;
            dir_q    <= dir_d;
        end
    end

    assign busy       = (fsm_q != FSM_IDLE) && (fsm_q != FSM_HALT);
    assign halted     = (fsm_q == FSM_HALT);
    assign err        = err_q;
    assign state_q    = mstate_q;
    assign step_count = step_q;
    assign tape_req   = req_q;
    assign tape_we    = we_q;
    assign tape_addr  = head;
    assign tape_wdata = wdata_q;
    assign lut_state  = mstate_q;
    assign lut_sym    = sym_q;
    assign fsm_dbg    = fsm_q;

endmodule

// File: tb/tb_utm_step_controller.sv
// Bench for utm_step_controller: tape memory responder, table-driven lookup, reference machine.
module tb_utm_step_controller;
    import utm_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        single_step;
    logic        step_go;
    logic        busy;
    logic        halted;
    logic [1:0]  err;
    logic [7:0]  state_q;
    logic [7:0]  head;
    logic [15:0] step_count;
    logic        tape_req;
    logic        tape_we;
    logic [7:0]  tape_addr;
    logic [2:0]  tape_wdata;
    logic [2:0]  tape_rdata;
    logic        tape_ack;
    logic [7:0]  lut_state;
    logic [2:0]  lut_sym;
    logic [7:0]  lut_next_state;
    logic [2:0]  lut_wsym;
    logic        lut_dir;
    fsm_state_e  fsm_dbg;

    logic [2:0]  mem    [256];
    logic [2:0]  m_tape [256];
    logic [7:0]  tab_ns [2048];
    logic [2:0]  tab_ws [2048];
    logic        tab_dir[2048];
    logic [11:0] log_q[$];
    int          ack_delay;
    int          stab_err;
    int          proto_err;
    int          n_tests;
    int          n_fail;

    utm_step_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .single_step    (single_step),
        .step_go        (step_go),
        .busy           (busy),
        .halted         (halted),
        .err            (err),
        .state_q        (state_q),
        .head           (head),
        .step_count     (step_count),
        .tape_req       (tape_req),
        .tape_we        (tape_we),
        .tape_addr      (tape_addr),
        .tape_wdata     (tape_wdata),
        .tape_rdata     (tape_rdata),
        .tape_ack       (tape_ack),
        .lut_state      (lut_state),
        .lut_sym        (lut_sym),
        .lut_next_state (lut_next_state),
        .lut_wsym       (lut_wsym),
        .lut_dir        (lut_dir),
        .fsm_dbg        (fsm_dbg)
    );

    // Transition tables indexed by {state, symbol}.
    assign lut_next_state = tab_ns[{lut_state, lut_sym}];
    assign lut_wsym       = tab_ws[{lut_state, lut_sym}];
    assign lut_dir        = tab_dir[{lut_state, lut_sym}];

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tape memory: acks after ack_delay waiting cycles, logs every transaction.
    initial begin : responder
        int          cnt;
        bit          ack_was;
        logic [11:0] cap;
        cnt = 0; ack_was = 0; cap = '0;
        tape_ack = 1'b0; tape_rdata = '0;
        forever begin
            @(negedge clk);
            tape_rdata = 3'($urandom);
            if (ack_was) begin
                tape_ack = 1'b0; ack_was = 0; cnt = 0;
                if (tape_req) proto_err++;
            end else if (tape_req) begin
                if (cnt == 0) cap = {tape_we, tape_addr, tape_wdata};
                else if ({tape_we, tape_addr, tape_wdata} !== cap) stab_err++;
                if (cnt >= ack_delay) begin
                    tape_ack = 1'b1; ack_was = 1;
                    if (tape_we) begin
                        mem[tape_addr] = tape_wdata;
                        log_q.push_back({1'b1, tape_addr, tape_wdata});
                    end else begin
                        tape_rdata = mem[tape_addr];
                        log_q.push_back({1'b0, tape_addr, mem[tape_addr]});
                    end
                end else begin
                    cnt++;
                end
            end else begin
                tape_ack = 1'b0; cnt = 0;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 3'd0;
    endtask

    task automatic clear_tab();
        for (int i = 0; i < 2048; i++) begin
            tab_ns[i] = 8'h00; tab_ws[i] = 3'd0; tab_dir[i] = 1'b0;
        end
    endtask

    task automatic set_entry(input logic [7:0] s, input logic [2:0] sym,
                             input logic [7:0] ns, input logic [2:0] ws, input logic d);
        tab_ns[{s, sym}] = ns; tab_ws[{s, sym}] = ws; tab_dir[{s, sym}] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; step_go = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        log_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Waits at negedges until IDLE/HALT (or PAUSE when auto_go=0); auto_go releases each PAUSE.
    task automatic wait_stop(input bit auto_go, input int limit, output int cycles, output bit ok);
        cycles = 0; ok = 0;
        for (int i = 0; i < limit; i++) begin
            if (fsm_dbg == FSM_HALT || fsm_dbg == FSM_IDLE || (fsm_dbg == FSM_PAUSE && !auto_go)) begin
                ok = 1; break;
            end
            step_go = auto_go && (fsm_dbg == FSM_PAUSE);
            cycles++;
            @(negedge clk);
        end
        step_go = 1'b0;
    endtask

    // Reference machine: runs the tables over a copy of mem from state 01, head 128.
    task automatic model_run(output int steps, output int h, output logic [7:0] st,
                             output logic [1:0] e, output int ntx, output bit done);
        int         hh;
        logic [7:0] s;
        logic [2:0] sym;
        logic [10:0] idx;
        logic [7:0] ns;
        for (int i = 0; i < 256; i++) m_tape[i] = mem[i];
        hh = 128; s = 8'h01; steps = 0; ntx = 0; done = 0; e = 2'b00;
        for (int k = 0; k < 300 && !done; k++) begin
            sym = m_tape[hh]; ntx++;
            if (sym == 3'b011) begin
                e = 2'b10; done = 1;
            end else begin
                idx = {s, sym}; ns = tab_ns[idx];
                m_tape[hh] = tab_ws[idx]; ntx++; steps++;
                if (ns == 8'h00) begin
                    s = 8'h00; done = 1;
                end else if ($countones(ns) != 1) begin
                    e = 2'b01; done = 1;
                end else begin
                    s = ns;
                    if ((hh == 0 && !tab_dir[idx]) || (hh == 255 && tab_dir[idx])) begin
                        e = 2'b11; done = 1;
                    end else begin
                        hh = tab_dir[idx] ? hh + 1 : hh - 1;
                    end
                end
            end
        end
        h = hh; st = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (tape_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", tape_req); end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if ({busy, halted, err} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, halted, err}); end
        n_tests++; if (state_q !== 8'h01) begin n_fail++; $display("FAIL reset_state: got %0h want 01", state_q); end
        n_tests++; if (head !== 8'd128) begin n_fail++; $display("FAIL reset_head: got %0d want 128", head); end
        n_tests++; if (step_count !== 16'd0) begin n_fail++; $display("FAIL reset_steps: got %0d want 0", step_count); end
        n_tests++; if ({tape_req, tape_we, tape_wdata, lut_sym} !== 8'h00) begin n_fail++; $display("FAIL reset_outs: got %0h want 0", {tape_req, tape_we, tape_wdata, lut_sym}); end
        n_tests++; if (lut_state !== 8'h01) begin n_fail++; $display("FAIL reset_lut_state: got %0h want 01", lut_state); end
    endtask

    task automatic test_first_step_and_single_step();
        int cyc; bit ok; logic [11:0] exp;
        do_reset(); clear_mem(); clear_tab();
        ack_delay = 0; single_step = 1'b1;
        set_entry(8'h01, 3'd0, 8'h02, 3'd1, 1'b0);
        set_entry(8'h02, 3'd0, 8'h04, 3'd2, 1'b1);
        set_entry(8'h04, 3'd1, 8'h08, 3'd3, 1'b1);
        pulse_start();
        wait_stop(0, 50, cyc, ok);
        n_tests++; if (!ok || cyc != 4) begin n_fail++; $display("FAIL first_step_cycles: got %0d ok %0b want 4", cyc, ok); end
        n_tests++; if (mem[128] !== 3'd1) begin n_fail++; $display("FAIL first_step_cell: got %0d want 1", mem[128]); end
        n_tests++; if (head !== 8'd127 || state_q !== 8'h02 || step_count !== 16'd1) begin n_fail++; $display("FAIL first_step_regs: head %0d state %0h steps %0d want 127 02 1", head, state_q, step_count); end
        exp = {1'b0, 8'd128, 3'd0};
        n_tests++; if (log_q.size() != 2 || log_q[0] !== exp) begin n_fail++; $display("FAIL first_step_read_txn: size %0d got %0h want %0h", log_q.size(), log_q[0], exp); end
        exp = {1'b1, 8'd128, 3'd1};
        n_tests++; if (log_q.size() != 2 || log_q[1] !== exp) begin n_fail++; $display("FAIL first_step_write_txn: size %0d got %0h want %0h", log_q.size(), log_q[1], exp); end
        n_tests++; if (fsm_dbg !== FSM_PAUSE || busy !== 1'b1) begin n_fail++; $display("FAIL pause_state: got %0d busy %0b want PAUSE busy 1", fsm_dbg, busy); end
        // step_go held across PAUSE and the following READ cycle: one step only.
        step_go = 1'b1; @(negedge clk); @(negedge clk); step_go = 1'b0;
        wait_stop(0, 50, cyc, ok);
        n_tests++; if (!ok || step_count !== 16'd2 || head !== 8'd128 || mem[127] !== 3'd2) begin n_fail++; $display("FAIL second_step: steps %0d head %0d cell %0d want 2 128 2", step_count, head, mem[127]); end
        // PAUSE must hold without step_go; start alone is ignored there.
        repeat (3) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (fsm_dbg !== FSM_PAUSE || step_count !== 16'd2 || state_q !== 8'h04) begin n_fail++; $display("FAIL pause_hold: fsm %0d steps %0d state %0h want PAUSE 2 04", fsm_dbg, step_count, state_q); end
        // start and step_go together: resume without reinitialising.
        start = 1'b1; step_go = 1'b1; @(negedge clk); start = 1'b0; step_go = 1'b0;
        wait_stop(0, 50, cyc, ok);
        n_tests++; if (!ok || step_count !== 16'd3 || head !== 8'd129 || state_q !== 8'h08 || mem[128] !== 3'd3) begin n_fail++; $display("FAIL go_beats_start: steps %0d head %0d state %0h cell %0d want 3 129 08 3", step_count, head, state_q, mem[128]); end
    endtask

    task automatic test_delayed_ack();
        int cyc; bit ok; int s0; int p0;
        do_reset(); clear_mem(); clear_tab();
        ack_delay = 3; single_step = 1'b1;
        set_entry(8'h01, 3'd0, 8'h02, 3'd1, 1'b0);
        s0 = stab_err; p0 = proto_err;
        pulse_start();
        wait_stop(0, 100, cyc, ok);
        n_tests++; if (!ok || cyc != 10) begin n_fail++; $display("FAIL delayed_cycles: got %0d ok %0b want 10", cyc, ok); end
        n_tests++; if (stab_err != s0 || proto_err != p0) begin n_fail++; $display("FAIL delayed_handshake: stable errs %0d proto errs %0d want 0 0", stab_err - s0, proto_err - p0); end
        n_tests++; if (mem[128] !== 3'd1 || head !== 8'd127 || log_q.size() != 2) begin n_fail++; $display("FAIL delayed_result: cell %0d head %0d txns %0d want 1 127 2", mem[128], head, log_q.size()); end
        ack_delay = 0;
    endtask

    task automatic test_invalid_symbol();
        int cyc; bit ok;
        do_reset(); clear_mem(); clear_tab();
        single_step = 1'b0; mem[128] = 3'b011;
        set_entry(8'h01, 3'b011, 8'h02, 3'd5, 1'b1);
        pulse_start();
        wait_stop(0, 100, cyc, ok);
        n_tests++; if (!ok || halted !== 1'b1 || err !== 2'b10) begin n_fail++; $display("FAIL invalid_sym_err: halted %0b err %b want 1 10", halted, err); end
        n_tests++; if (step_count !== 16'd0 || log_q.size() != 1 || mem[128] !== 3'b011) begin n_fail++; $display("FAIL invalid_sym_nowrite: steps %0d txns %0d cell %0d want 0 1 3", step_count, log_q.size(), mem[128]); end
    endtask

    task automatic test_bad_next_state();
        int cyc; bit ok;
        do_reset(); clear_mem(); clear_tab();
        single_step = 1'b0;
        set_entry(8'h01, 3'd0, 8'h06, 3'd5, 1'b1);
        pulse_start();
        wait_stop(0, 100, cyc, ok);
        n_tests++; if (!ok || err !== 2'b01 || state_q !== 8'h01) begin n_fail++; $display("FAIL bad_next_state: err %b state %0h want 01 01", err, state_q); end
        n_tests++; if (step_count !== 16'd1 || mem[128] !== 3'd5 || head !== 8'd128) begin n_fail++; $display("FAIL bad_next_regs: steps %0d cell %0d head %0d want 1 5 128", step_count, mem[128], head); end
    endtask

    task automatic test_normal_halt_restart();
        int cyc; bit ok;
        do_reset(); clear_mem(); clear_tab();
        single_step = 1'b0;
        set_entry(8'h01, 3'd0, 8'h00, 3'd4, 1'b1);
        pulse_start();
        wait_stop(0, 100, cyc, ok);
        n_tests++; if (!ok || err !== 2'b00 || halted !== 1'b1 || state_q !== 8'h00 || head !== 8'd128) begin n_fail++; $display("FAIL normal_halt: err %b halted %0b state %0h head %0d want 00 1 00 128", err, halted, state_q, head); end
        mem[128] = 3'd0; log_q.delete();
        pulse_start();
        wait_stop(0, 100, cyc, ok);
        n_tests++; if (!ok || step_count !== 16'd1 || log_q.size() != 2 || mem[128] !== 3'd4) begin n_fail++; $display("FAIL halt_restart: steps %0d txns %0d cell %0d want 1 2 4", step_count, log_q.size(), mem[128]); end
    endtask

    task automatic test_tape_edges();
        int cyc; bit ok;
        do_reset(); clear_mem(); clear_tab();
        single_step = 1'b0;
        set_entry(8'h01, 3'd0, 8'h01, 3'd1, 1'b0);
        pulse_start();
        wait_stop(0, 2000, cyc, ok);
        n_tests++; if (!ok || err !== 2'b11 || head !== 8'd0 || step_count !== 16'd129 || mem[0] !== 3'd1) begin n_fail++; $display("FAIL left_edge: err %b head %0d steps %0d cell0 %0d want 11 0 129 1", err, head, step_count, mem[0]); end
        do_reset(); clear_mem(); clear_tab();
        set_entry(8'h01, 3'd0, 8'h01, 3'd2, 1'b1);
        pulse_start();
        wait_stop(0, 2000, cyc, ok);
        n_tests++; if (!ok || err !== 2'b11 || head !== 8'd255 || step_count !== 16'd128 || mem[255] !== 3'd2) begin n_fail++; $display("FAIL right_edge: err %b head %0d steps %0d cell255 %0d want 11 255 128 2", err, head, step_count, mem[255]); end
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        do_reset(); clear_mem(); clear_tab();
        single_step = 1'b0; ack_delay = 20;
        set_entry(8'h01, 3'd0, 8'h02, 3'd1, 1'b0);
        pulse_start();
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (fsm_dbg == FSM_WRITE && tape_req) seen = 1; else @(negedge clk);
        end
        repeat (2) @(negedge clk);
        n_tests++; if (!seen || tape_we !== 1'b1) begin n_fail++; $display("FAIL mid_write_reached: seen %0b we %0b want 1 1", seen, tape_we); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (tape_req !== 1'b0 || tape_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_write_reset: req %0b we %0b busy %0b want 0 0 0", tape_req, tape_we, busy); end
        n_tests++; if (state_q !== 8'h01 || head !== 8'd128 || step_count !== 16'd0 || err !== 2'b00 || lut_sym !== 3'd0 || tape_wdata !== 3'd0) begin n_fail++; $display("FAIL mid_write_regs: state %0h head %0d steps %0d err %b sym %0d wdata %0d", state_q, head, step_count, err, lut_sym, tape_wdata); end
        @(negedge clk); rst_n = 1'b1; ack_delay = 0;
    endtask

    task automatic test_random();
        int steps; int h; logic [7:0] st; logic [1:0] e; int ntx; bit done;
        int tries; int cyc; bit ok; int bad; int r; logic [7:0] s;
        for (int it = 0; it < 10; it++) begin
            do_reset();
            tries = 0;
            do begin
                for (int i = 0; i < 256; i++) begin
                    mem[i] = 3'($urandom_range(0, 7));
                    if (mem[i] == 3'b011 && $urandom_range(0, 3) != 0) mem[i] = 3'd0;
                end
                clear_tab();
                for (int si = 0; si < 4; si++) begin
                    for (int sy = 0; sy < 8; sy++) begin
                        s = 8'h01 << si;
                        r = $urandom_range(0, 15);
                        set_entry(s, 3'(sy),
                                  (r == 0) ? 8'h00 : (r == 1) ? 8'($urandom_range(1, 255)) : 8'h01 << $urandom_range(0, 3),
                                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                    end
                end
                model_run(steps, h, st, e, ntx, done);
                tries++;
            end while (!done && tries < 20);
            if (!done) continue;
            ack_delay = $urandom_range(0, 2); single_step = 1'($urandom_range(0, 1));
            pulse_start();
            wait_stop(1, 20000, cyc, ok);
            n_tests++; if (!ok || halted !== 1'b1) begin n_fail++; $display("FAIL rand_%0d_halt: ok %0b halted %0b want 1 1", it, ok, halted); end
            n_tests++; if (err !== e || state_q !== st || head !== 8'(h) || step_count !== 16'(steps)) begin n_fail++; $display("FAIL rand_%0d_regs: err %b state %0h head %0d steps %0d want %b %0h %0d %0d", it, err, state_q, head, step_count, e, st, h, steps); end
            bad = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== m_tape[i]) bad++;
            n_tests++; if (bad != 0 || log_q.size() != ntx) begin n_fail++; $display("FAIL rand_%0d_tape: bad cells %0d txns %0d want 0 %0d", it, bad, log_q.size(), ntx); end
        end
        ack_delay = 0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; stab_err = 0; proto_err = 0;
        rst_n = 1'b0; start = 1'b0; single_step = 1'b0; step_go = 1'b0; ack_delay = 0;
        clear_mem(); clear_tab();
        test_reset();
        test_first_step_and_single_step();
        test_delayed_ack();
        test_invalid_symbol();
        test_bad_next_state();
        test_normal_halt_restart();
        test_tape_edges();
        test_reset_mid_write();
        test_random();
        n_tests++; if (stab_err != 0 || proto_err != 0) begin n_fail++; $display("FAIL handshake_totals: stable errs %0d proto errs %0d want 0 0", stab_err, proto_err); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
